// File: rtl/int8_mac_accum_pkg.sv
// Shared definitions for the int8 MAC accumulate / requantise block:
// FSM state encodings and the default input widths.
package int8_mac_accum_pkg;

  localparam int PSUM_W  = 24;
  localparam int SCALE_W = 8;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_MUL = 2'd1,
    ST_OUT = 2'd2
  } state_e;

endpackage : int8_mac_accum_pkg

// File: rtl/int8_mac_accum_if.sv
// Beat stream from the MAC (valid/ready) and result stream to writeback
// (valid/ready), grouped so that both sides connect through one bundle.
interface int8_mac_accum_if
  import int8_mac_accum_pkg::*;
#(
  parameter int OUT_W = 24
);

  logic               in_valid;
  logic               in_ready;
  logic [PSUM_W-1:0]  psum_in;
  logic [SCALE_W-1:0] scale_a;
  logic [SCALE_W-1:0] scale_b;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_sat;
  logic               out_ovf;
  logic               out_trunc;

  modport master (
    output in_valid, psum_in, scale_a, scale_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_ovf, out_trunc
  );

  modport slave (
    input  in_valid, psum_in, scale_a, scale_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_ovf, out_trunc
  );

endinterface : int8_mac_accum_if

// File: rtl/int8_requant.sv
// Combinational requantiser: acc * sa * sb, round half-up, shift right by
// SHIFT and saturate to OUT_W bits. The caller registers the outputs.
module int8_requant
  import int8_mac_accum_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 24,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [SCALE_W-1:0] sa,
  input  logic [SCALE_W-1:0] sb,
  output logic [OUT_W-1:0]   data,
  output logic               sat
);

  localparam int PROD_W  = ACC_W + 2 * SCALE_W;
  // One extra bit so the rounding add can never wrap.
  localparam int SUM_W   = PROD_W + 1;
  localparam int RND_POS = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam logic [SUM_W-1:0] RND_ADD =
    (SHIFT > 0) ? (SUM_W'(1) << RND_POS) : {SUM_W{1'b0}};

  logic [PROD_W-1:0] prod_s;
  logic [SUM_W-1:0]  rounded_s;
  logic [SUM_W-1:0]  shifted_s;

  // Full-precision product, rounding, shift and clamp to the output range
  always_comb begin
    prod_s    = PROD_W'(acc) * PROD_W'(sa) * PROD_W'(sb);
    rounded_s = {1'b0, prod_s} + RND_ADD;
    shifted_s = rounded_s >> SHIFT;
    if (|shifted_s[SUM_W-1:OUT_W]) begin
      data = {OUT_W{1'b1}};
      sat  = 1'b1;
    end else begin
      data = shifted_s[OUT_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule : int8_requant

// File: rtl/int8_mac_accum.sv
// Tile accumulator behind the int8 dot-product MAC. Sums 24-bit partial
// sums with saturation, requantises the tile total by the first-beat scale
// factors and hands one result per tile to writeback.
module int8_mac_accum
  import int8_mac_accum_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 24,
  parameter int SHIFT     = 8,
  parameter int MAX_BEATS = 64
) (
  input logic             clk,
  input logic             rst_n,
  int8_mac_accum_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e             state_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic [SCALE_W-1:0] sa_r;
  logic [SCALE_W-1:0] sb_r;
  logic               ovf_r;
  logic               trunc_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [OUT_W-1:0]   out_data_r;
  logic               out_sat_r;
  logic               out_ovf_r;
  logic               out_trunc_r;

  logic               accept_s;
  logic [ACC_W-1:0]   acc_next_s;
  logic               acc_clamp_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               hit_max_s;
  logic [OUT_W-1:0]   rq_data_s;
  logic               rq_sat_s;

  // Saturating add of a zero-extended partial sum; MSB flags the clamp.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                             input logic [PSUM_W-1:0] p);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W + 1 - PSUM_W){1'b0}}, p};
    if (sum[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  // Beat acceptance, next accumulator value and tile-length bookkeeping
  always_comb begin
    accept_s = 1'b0;
    if (state_r == ST_ACC) begin
      accept_s = bus.in_valid & in_ready_r;
    end else begin
      accept_s = 1'b0;
    end
    {acc_clamp_s, acc_next_s} = sat_add(acc_r, bus.psum_in);
    cnt_inc_s = beat_cnt_r + CNT_W'(1);
    hit_max_s = (cnt_inc_s == CNT_W'(MAX_BEATS));
  end

  int8_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc  (acc_r),
    .sa   (sa_r),
    .sb   (sb_r),
    .data (rq_data_s),
    .sat  (rq_sat_s)
  );

  // Tile FSM: accumulate in ACC, requantise in MUL, hold result in OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_ACC;
      acc_r       <= {ACC_W{1'b0}};
      beat_cnt_r  <= {CNT_W{1'b0}};
      sa_r        <= {SCALE_W{1'b0}};
      sb_r        <= {SCALE_W{1'b0}};
      ovf_r       <= 1'b0;
      trunc_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      out_sat_r   <= 1'b0;
      out_ovf_r   <= 1'b0;
      out_trunc_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (accept_s) begin
            acc_r      <= acc_next_s;
            beat_cnt_r <= cnt_inc_s;
            ovf_r      <= ovf_r | acc_clamp_s;
            // Only the first beat of a tile carries the scale factors.
            if (beat_cnt_r == {CNT_W{1'b0}}) begin
              sa_r <= bus.scale_a;
              sb_r <= bus.scale_b;
            end else begin
              sa_r <= sa_r;
              sb_r <= sb_r;
            end
            if (bus.in_last || hit_max_s) begin
              state_r    <= ST_MUL;
              in_ready_r <= 1'b0;
              trunc_r    <= ~bus.in_last;
            end else begin
              state_r <= ST_ACC;
            end
          end else begin
            state_r <= ST_ACC;
          end
        end
        ST_MUL: begin
          out_data_r  <= rq_data_s;
          out_sat_r   <= rq_sat_s;
          out_ovf_r   <= ovf_r;
          out_trunc_r <= trunc_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            acc_r       <= {ACC_W{1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            trunc_r     <= 1'b0;
            state_r     <= ST_ACC;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          acc_r       <= {ACC_W{1'b0}};
          beat_cnt_r  <= {CNT_W{1'b0}};
          ovf_r       <= 1'b0;
          trunc_r     <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_trunc = out_trunc_r;

endmodule : int8_mac_accum

// File: tb/tb_int8_mac_accum.sv
// Directed bench for int8_mac_accum. Three instances share one stimulus:
// u0 default parameters, u1 ACC_W=24/SHIFT=0, u2 MAX_BEATS=4. A reset
// separates each scenario so each instance starts clean.
module tb_int8_mac_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] psum;
  logic [7:0]  sa;
  logic [7:0]  sb;
  logic        last;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int8_mac_accum_if #(.OUT_W(24)) if0 ();
  int8_mac_accum_if #(.OUT_W(24)) if1 ();
  int8_mac_accum_if #(.OUT_W(24)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.psum_in  = psum;      assign if1.psum_in  = psum;      assign if2.psum_in  = psum;
  assign if0.scale_a  = sa;        assign if1.scale_a  = sa;        assign if2.scale_a  = sa;
  assign if0.scale_b  = sb;        assign if1.scale_b  = sb;        assign if2.scale_b  = sb;
  assign if0.in_last  = last;      assign if1.in_last  = last;      assign if2.in_last  = last;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  int8_mac_accum #(.ACC_W(32), .OUT_W(24), .SHIFT(8), .MAX_BEATS(64))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  int8_mac_accum #(.ACC_W(24), .OUT_W(24), .SHIFT(0), .MAX_BEATS(64))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  int8_mac_accum #(.ACC_W(32), .OUT_W(24), .SHIFT(8), .MAX_BEATS(4))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic beat(input logic [23:0] p, input logic [7:0] a, input logic [7:0] b, input logic l);
    in_valid = 1'b1;
    psum     = p;
    sa       = a;
    sb       = b;
    last     = l;
    tick();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    psum      = 24'd0;
    sa        = 8'd0;
    sb        = 8'd0;
    last      = 1'b0;
    out_ready = 1'b1;
    tick();
    do_reset();

    // Reset state
    check("rst_in_ready",  if0.in_ready,  1'b1);
    check("rst_out_valid", if0.out_valid, 1'b0);
    check("rst_out_data",  if0.out_data,  24'd0);
    check("rst_flags",     {if0.out_sat, if0.out_ovf, if0.out_trunc}, 3'b000);

    // Basic tile: (600*2*3 + 128) >> 8 = 14
    beat(24'd100, 8'd2, 8'd3, 1'b0);
    beat(24'd200, 8'd2, 8'd3, 1'b0);
    beat(24'd300, 8'd2, 8'd3, 1'b1);
    check("basic_mul_valid", if0.out_valid, 1'b0);
    check("basic_mul_ready", if0.in_ready,  1'b0);
    tick();
    check("basic_valid", if0.out_valid, 1'b1);
    check("basic_data",  if0.out_data,  24'd14);
    check("basic_flags", {if0.out_sat, if0.out_ovf, if0.out_trunc}, 3'b000);
    tick();
    check("basic_drop_valid", if0.out_valid, 1'b0);
    check("basic_ready_back", if0.in_ready,  1'b1);
    check("basic_data_kept",  if0.out_data,  24'd14);

    // Later-beat scale changes are ignored
    beat(24'd100, 8'd2, 8'd3, 1'b0);
    beat(24'd200, 8'd9, 8'd9, 1'b0);
    beat(24'd300, 8'd9, 8'd9, 1'b1);
    tick();
    check("scale_valid", if0.out_valid, 1'b1);
    check("scale_data",  if0.out_data,  24'd14);
    tick();

    // Output saturation, single-beat tile
    beat(24'hFFFFFF, 8'd255, 8'd255, 1'b1);
    tick();
    check("osat_valid", if0.out_valid, 1'b1);
    check("osat_data",  if0.out_data,  24'hFFFFFF);
    check("osat_flags", {if0.out_sat, if0.out_ovf, if0.out_trunc}, 3'b100);
    tick();

    // Accumulator overflow on the 24-bit instance
    do_reset();
    beat(24'hFFFFFF, 8'd1, 8'd1, 1'b0);
    beat(24'd1,      8'd1, 8'd1, 1'b1);
    tick();
    check("aovf_valid", if1.out_valid, 1'b1);
    check("aovf_data",  if1.out_data,  24'hFFFFFF);
    check("aovf_flags", {if1.out_sat, if1.out_ovf, if1.out_trunc}, 3'b010);
    tick();

    // Truncation at MAX_BEATS=4: (4*256 + 128) >> 8 = 4
    do_reset();
    for (int i = 0; i < 4; i++) beat(24'd1, 8'd16, 8'd16, 1'b0);
    check("trunc_mul_ready", if2.in_ready, 1'b0);
    tick();
    check("trunc_valid", if2.out_valid, 1'b1);
    check("trunc_data",  if2.out_data,  24'd4);
    check("trunc_flags", {if2.out_sat, if2.out_ovf, if2.out_trunc}, 3'b001);
    tick();
    check("trunc_ready_back", if2.in_ready, 1'b1);
    beat(24'd5, 8'd16, 8'd16, 1'b1);
    tick();
    check("trunc_next_data",  if2.out_data, 24'd5);
    check("trunc_next_flags", {if2.out_sat, if2.out_ovf, if2.out_trunc}, 3'b000);
    tick();

    // Backpressure: result held for 5 cycles, beats offered meanwhile are refused
    do_reset();
    out_ready = 1'b0;
    beat(24'd100, 8'd2, 8'd3, 1'b0);
    beat(24'd200, 8'd2, 8'd3, 1'b0);
    beat(24'd300, 8'd2, 8'd3, 1'b1);
    tick();
    in_valid = 1'b1;
    psum     = 24'd1000;
    sa       = 8'd16;
    sb       = 8'd16;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", if0.out_valid, 1'b1);
      check("bp_data",  if0.out_data,  24'd14);
      check("bp_ready", if0.in_ready,  1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_released_valid", if0.out_valid, 1'b0);
    check("bp_released_ready", if0.in_ready,  1'b1);
    beat(24'd5, 8'd16, 8'd16, 1'b1);
    tick();
    check("bp_after_data", if0.out_data, 24'd5);
    tick();

    // Reset mid-tile discards the partial sum
    beat(24'd7, 8'd16, 8'd16, 1'b0);
    beat(24'd7, 8'd16, 8'd16, 1'b0);
    do_reset();
    check("midrst_valid", if0.out_valid, 1'b0);
    check("midrst_ready", if0.in_ready,  1'b1);
    check("midrst_data",  if0.out_data,  24'd0);
    beat(24'd5, 8'd16, 8'd16, 1'b1);
    tick();
    check("midrst_next_valid", if0.out_valid, 1'b1);
    check("midrst_next_data",  if0.out_data,  24'd5);
    check("midrst_next_flags", {if0.out_sat, if0.out_ovf, if0.out_trunc}, 3'b000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_int8_mac_accum
